// File: rtl/qlm_dot_accumulator.sv
// Streaming dot-product accumulator behind the QLM log multiplier: folds the
// ones'-complement correction into the accumulate add and emits one sum per vector.
module qlm_dot_accumulator #(
  parameter int ACC_W   = 40,
  parameter int MAX_LEN = 256,
  parameter bit SAT     = 1'b1,
  localparam int CNT_W  = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p,
  input  logic             in_neg,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W:0]   base_x, term_x, sum_x;
  logic             ovf_now;
  logic [ACC_W-1:0] sum_fix;
  logic [CNT_W-1:0] count_inc;
  logic             close_vec;

  assign in_ready  = (state_q != S_DONE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

  // in_neg rides in as the carry-in, turning the ones'-complement word into two's complement
  assign term_x  = {{(ACC_W+1-32){in_p[31]}}, in_p} + (ACC_W+1)'(in_neg);
  assign base_x  = (state_q == S_IDLE) ? '0 : {acc_q[ACC_W-1], acc_q};
  assign sum_x   = base_x + term_x;
  assign ovf_now = sum_x[ACC_W] ^ sum_x[ACC_W-1];

  always_comb begin
    sum_fix = sum_x[ACC_W-1:0];
    if (SAT && ovf_now) begin
      sum_fix = sum_x[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign count_inc = (state_q == S_IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
  assign close_vec = in_last | (count_inc == CNT_MAX);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (accept) begin
          acc_d   = sum_fix;
          count_d = count_inc;
          ovf_d   = ovf_q | ovf_now;
          state_d = close_vec ? S_DONE : S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
